pointwise_conv_engine: RTL and testbench
========================================

POINTWISE_CONV_ENGINE -- requirements
Module: pointwise_conv_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed fixed-point data width of pixels, weights, bias and outputs.
REQ-002 SHALL have parameter DSP_NO, default 16: number of parallel MAC lanes (output channels per group).
REQ-003 SHALL have parameter CHIN, default 512: input channels per pixel.
REQ-004 SHALL have parameter CHOUT, default 112: output channels; an integer multiple of DSP_NO; GROUPS = CHOUT/DSP_NO.
REQ-005 SHALL have parameter PIX, default 64: pixels per frame (H_IN*W_IN).
REQ-006 SHALL have parameter FRAC, default 8: fractional bits of the data format.
REQ-007 SHALL have parameter RELU_EN, default 1: 1 = clamp negative results to 0.
REQ-008 clk  in  1  clock.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  single-cycle layer start pulse.
REQ-011 ifm  in  WIDTH  input channel value, order: group, pixel, channel; stream replayed once per group.
REQ-012 ifm_valid  in  1 / ifm_ready  out  1  input handshake; transfer when both high.
REQ-013 wt_addr  out  clog2(GROUPS*CHIN)  weight ROM address = g*CHIN + c.
REQ-014 wt_data  in  DSP_NO*WIDTH  weight ROM data, valid exactly 1 cycle after wt_addr.
REQ-015 bias_data  in  DSP_NO*WIDTH  bias of current group, indexed by ofm_grp, combinational.
REQ-016 ofm  out  DSP_NO*WIDTH  output vector; ofm_valid  out  1; ofm_ready  in  1.
REQ-017 ofm_pix  out  clog2(PIX) / ofm_grp  out  clog2(GROUPS)  coordinates of current ofm.
REQ-018 busy  out  1 / done  out  1  layer active / single-cycle completion pulse.

Function
REQ-019 FSM states IDLE, ACCUM, FLUSH, EMIT, FIN; IDLE->ACCUM on start; ACCUM->FLUSH after channel CHIN-1 transferred; FLUSH->EMIT after 1 cycle; EMIT->ACCUM on ofm handshake unless last pixel of last group, then ->FIN; FIN->IDLE after 1 cycle asserting done.
REQ-020 start while busy SHALL be ignored.
REQ-021 ifm_ready SHALL be high only in ACCUM; ifm_valid low SHALL freeze channel counter, wt_addr and accumulators.
REQ-022 wt_addr SHALL advance on each accepted ifm; ifm SHALL be delayed one register stage to align with wt_data.
REQ-023 Each lane accumulator SHALL be 2*WIDTH+clog2(CHIN) bits signed, cleared on first product of each pixel (no dead clear cycle).
REQ-024 Result = (acc + (bias sign-extended << FRAC)) arithmetically shifted right FRAC, saturated to signed WIDTH range, then ReLU if RELU_EN.
REQ-025 ofm SHALL be registered, ofm_valid high throughout EMIT, ofm/ofm_pix/ofm_grp stable until handshake.
REQ-026 Channel, pixel, group counters SHALL wrap to 0 at CHIN-1, PIX-1, GROUPS-1 respectively.
REQ-027 Pipeline latency: last channel accepted -> ofm_valid = 2 cycles.
REQ-028 Whole design SHALL run on clk only; no derived or gated clocks.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, all counters 0, accumulators 0, ofm 0, ofm_valid 0, ifm_ready 0, busy 0, done 0, wt_addr 0.
REQ-030 Reset mid-layer SHALL abort; next start begins at group 0, pixel 0.

Structure
REQ-031 State enum, fixed-point saturate/ReLU function and GROUPS computation SHALL live in shared package cnn_pkg.
REQ-032 One sub-module mac_lane (clear-on-first, enable, wide accumulator) SHALL be instantiated DSP_NO times.

Verification
REQ-033 DSP_NO=2, CHIN=4, CHOUT=4, PIX=2, ifm all 0x0100, weights 0x0100, bias 0 -> ofm each lane 0x0400, 4 EMITs, one done pulse.
REQ-034 Negative sum (ifm 0x0100, weight 0xFF00) with RELU_EN=1 -> ofm 0x0000; RELU_EN=0 -> 0xFC00.
REQ-035 Overflow (ifm 0x7FFF, weight 0x7FFF, CHIN=4) -> ofm 0x7FFF saturated.
REQ-036 Random ifm_valid gaps and ofm_ready held low 5 cycles -> results match reference model, ofm stable while stalled.
REQ-037 rst asserted during group 1 ACCUM -> all outputs 0 same cycle; subsequent start yields full correct layer.
REQ-038 start pulsed while busy -> no effect on sequence or output count.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnn_pkg : shared FSM states, width helpers and fixed-point clamp   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_FLUSH = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int groups(input int chout, input int dsp_no);
    return chout / dsp_no;
  endfunction

  // Clamp to the signed range of `width` bits, then optionally zero negatives.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int width,
                                                  input logic relu);
    logic signed [63:0] vmax;
    logic signed [63:0] vmin;
    logic signed [63:0] r;
    vmax = (64'sd1 <<< (width - 1)) - 64'sd1;
    vmin = -(64'sd1 <<< (width - 1));
    if (v > vmax)      r = vmax;
    else if (v < vmin) r = vmin;
    else               r = v;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pointwise_conv_engine_mac_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_lane : signed multiply-accumulate, clears on first product      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mac_lane #(
  parameter int WIDTH = 16,
  parameter int ACCW  = 41
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_first,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [ACCW-1:0]  o_acc_nxt
);

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [ACCW-1:0]    w_prod_ext;
  logic signed [ACCW-1:0]    w_acc_nxt;
  logic signed [ACCW-1:0]    r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACCW-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
  // First product of a pixel replaces the old sum, so no separate clear cycle.
  assign w_acc_nxt  = i_first ? w_prod_ext : (r_acc + w_prod_ext);
  assign o_acc_nxt  = w_acc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_acc <= '0;
    else if (i_en) r_acc <= w_acc_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/pointwise_conv_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pointwise_conv_engine : 1x1 conv, DSP_NO output channels per group |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pointwise_conv_engine
  import cnn_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DSP_NO  = 16,
  parameter int CHIN    = 512,
  parameter int CHOUT   = 112,
  parameter int PIX     = 64,
  parameter int FRAC    = 8,
  parameter int RELU_EN = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [WIDTH-1:0]                              ifm,
  input  logic                                          ifm_valid,
  output logic                                          ifm_ready,
  output logic [clog2w(groups(CHOUT,DSP_NO)*CHIN)-1:0]  wt_addr,
  input  logic [DSP_NO*WIDTH-1:0]                       wt_data,
  input  logic [DSP_NO*WIDTH-1:0]                       bias_data,
  output logic [DSP_NO*WIDTH-1:0]                       ofm,
  output logic                                          ofm_valid,
  input  logic                                          ofm_ready,
  output logic [clog2w(PIX)-1:0]                        ofm_pix,
  output logic [clog2w(groups(CHOUT,DSP_NO))-1:0]       ofm_grp,
  output logic                                          busy,
  output logic                                          done
);

  localparam int c_groups = groups(CHOUT, DSP_NO);
  localparam int c_cw     = clog2w(CHIN);
  localparam int c_pw     = clog2w(PIX);
  localparam int c_gw     = clog2w(c_groups);
  localparam int c_aw     = clog2w(c_groups * CHIN);
  localparam int c_accw   = 2 * WIDTH + c_cw;
  localparam logic [c_aw-1:0] c_chin_a = c_aw'(CHIN);

  state_t                     r_state;
  logic [c_cw-1:0]            r_chan;
  logic [c_pw-1:0]            r_pix;
  logic [c_gw-1:0]            r_grp;
  logic [c_aw-1:0]            r_wt_addr;
  logic [WIDTH-1:0]           r_ifm_d;
  logic                       r_first;
  logic                       r_acc_en;
  logic                       r_ifm_ready;
  logic                       r_ofm_valid;
  logic                       r_busy;
  logic                       r_done;
  logic [DSP_NO*WIDTH-1:0]    r_ofm;

  logic                       w_accept;
  logic                       w_chan_last;
  logic                       w_pix_last;
  logic                       w_grp_last;
  logic [c_gw-1:0]            w_grp_nxt;
  logic [c_aw-1:0]            w_grp_base;
  logic [c_aw-1:0]            w_next_base;
  logic [DSP_NO*WIDTH-1:0]    w_res;

  assign w_accept    = ifm_valid & r_ifm_ready;
  assign w_chan_last = (r_chan == c_cw'(CHIN - 1));
  assign w_pix_last  = (r_pix == c_pw'(PIX - 1));
  assign w_grp_last  = (r_grp == c_gw'(c_groups - 1));
  assign w_grp_nxt   = r_grp + 1'b1;
  assign w_grp_base  = c_aw'(r_grp) * c_chin_a;
  assign w_next_base = c_aw'(w_grp_nxt) * c_chin_a;

  // ifm is held one stage so it meets the ROM word fetched for the same address.
  for (genvar l = 0; l < DSP_NO; l++) begin : g_lane
    logic signed [c_accw-1:0] w_acc_nxt;
    logic signed [c_accw:0]   w_acc_ext;
    logic signed [c_accw:0]   w_bias_ext;
    logic signed [c_accw:0]   w_sum;
    logic signed [c_accw:0]   w_shift;
    logic signed [63:0]       w_wide;

    mac_lane #(
      .WIDTH (WIDTH),
      .ACCW  (c_accw)
    ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .i_en      (r_acc_en),
      .i_first   (r_first),
      .i_a       (r_ifm_d),
      .i_b       (wt_data[l*WIDTH +: WIDTH]),
      .o_acc_nxt (w_acc_nxt)
    );

    assign w_acc_ext  = {w_acc_nxt[c_accw-1], w_acc_nxt};
    assign w_bias_ext = {{(c_accw+1-WIDTH){bias_data[l*WIDTH+WIDTH-1]}},
                         bias_data[l*WIDTH +: WIDTH]};
    assign w_sum      = w_acc_ext + (w_bias_ext <<< FRAC);
    assign w_shift    = w_sum >>> FRAC;
    assign w_wide     = {{(63-c_accw){w_shift[c_accw]}}, w_shift};
    assign w_res[l*WIDTH +: WIDTH] = WIDTH'(sat_relu(w_wide, WIDTH, RELU_EN != 0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_chan      <= '0;
      r_pix       <= '0;
      r_grp       <= '0;
      r_wt_addr   <= '0;
      r_ifm_d     <= '0;
      r_first     <= 1'b0;
      r_acc_en    <= 1'b0;
      r_ifm_ready <= 1'b0;
      r_ofm_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ofm       <= '0;
    end else begin
      r_done   <= 1'b0;
      r_acc_en <= w_accept;
      if (w_accept) begin
        r_ifm_d <= ifm;
        r_first <= (r_chan == '0);
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_ACCUM;
            r_ifm_ready <= 1'b1;
            r_busy      <= 1'b1;
            r_chan      <= '0;
            r_pix       <= '0;
            r_grp       <= '0;
            r_wt_addr   <= '0;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_chan_last) begin
              r_chan      <= '0;
              r_wt_addr   <= w_grp_base;
              r_ifm_ready <= 1'b0;
              r_state     <= ST_FLUSH;
            end else begin
              r_chan    <= r_chan + 1'b1;
              r_wt_addr <= r_wt_addr + 1'b1;
            end
          end
        end
        // Last product is folded in combinationally so ofm lands with EMIT.
        ST_FLUSH: begin
          r_ofm       <= w_res;
          r_ofm_valid <= 1'b1;
          r_state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (ofm_ready) begin
            r_ofm_valid <= 1'b0;
            if (w_pix_last) begin
              r_pix <= '0;
              if (w_grp_last) begin
                r_grp     <= '0;
                r_wt_addr <= '0;
                r_done    <= 1'b1;
                r_state   <= ST_FIN;
              end else begin
                r_grp       <= w_grp_nxt;
                r_wt_addr   <= w_next_base;
                r_ifm_ready <= 1'b1;
                r_state     <= ST_ACCUM;
              end
            end else begin
              r_pix       <= r_pix + 1'b1;
              r_ifm_ready <= 1'b1;
              r_state     <= ST_ACCUM;
            end
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ifm_ready = r_ifm_ready;
  assign wt_addr   = r_wt_addr;
  assign ofm       = r_ofm;
  assign ofm_valid = r_ofm_valid;
  assign ofm_pix   = r_pix;
  assign ofm_grp   = r_grp;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pointwise_conv_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pointwise_conv_engine : directed checks, ReLU on and off DUTs   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pointwise_conv_engine;

  localparam int WIDTH  = 16;
  localparam int DSP_NO = 2;
  localparam int CHIN   = 4;
  localparam int CHOUT  = 4;
  localparam int PIX    = 2;
  localparam int FRAC   = 8;
  localparam int VW     = DSP_NO * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] ifm = '0;
  logic             ifm_valid = 1'b0;
  logic             ofm_ready = 1'b1;
  logic [VW-1:0]    wt_data = '0;
  logic [VW-1:0]    bias0, bias1, ofm0, ofm1;
  logic             ifm_ready0, ifm_ready1, ofm_valid0, ofm_valid1;
  logic             busy0, busy1, done0, done1;
  logic [2:0]       wt_addr0, wt_addr1;
  logic [0:0]       ofm_pix0, ofm_pix1, ofm_grp0, ofm_grp1;

  logic [VW-1:0]    wt_mem   [0:7];
  logic [VW-1:0]    bias_mem [0:1];
  logic [15:0]      ifm_mem  [0:1][0:3];

  logic [VW-1:0]    got0 [0:7];
  logic [VW-1:0]    got1 [0:7];
  int               got_pix [0:7];
  int               got_grp [0:7];
  int               n_emit, n_done, n_unstable, timed_out;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) wt_data <= wt_mem[wt_addr0];
  assign bias0 = bias_mem[ofm_grp0];
  assign bias1 = bias_mem[ofm_grp1];

  pointwise_conv_engine #(
    .WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN), .CHOUT(CHOUT),
    .PIX(PIX), .FRAC(FRAC), .RELU_EN(1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .ifm(ifm), .ifm_valid(ifm_valid),
    .ifm_ready(ifm_ready0), .wt_addr(wt_addr0), .wt_data(wt_data),
    .bias_data(bias0), .ofm(ofm0), .ofm_valid(ofm_valid0), .ofm_ready(ofm_ready),
    .ofm_pix(ofm_pix0), .ofm_grp(ofm_grp0), .busy(busy0), .done(done0)
  );

  pointwise_conv_engine #(
    .WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN), .CHOUT(CHOUT),
    .PIX(PIX), .FRAC(FRAC), .RELU_EN(0)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .ifm(ifm), .ifm_valid(ifm_valid),
    .ifm_ready(ifm_ready1), .wt_addr(wt_addr1), .wt_data(wt_data),
    .bias_data(bias1), .ofm(ofm1), .ofm_valid(ofm_valid1), .ofm_ready(ofm_ready),
    .ofm_pix(ofm_pix1), .ofm_grp(ofm_grp1), .busy(busy1), .done(done1)
  );

  task automatic load_uniform(input logic [15:0] x, input logic [15:0] w);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++) ifm_mem[p][c] = x;
    for (int a = 0; a < 8; a++) wt_mem[a] = {w, w};
    bias_mem[0] = '0;
    bias_mem[1] = '0;
  endtask

  // Streams one layer (group, pixel, channel order) and records every ofm handshake.
  task automatic run_layer(input bit gap, input int stall, input bit dbl_start, input bit abort_g1);
    int c, p, g, stall_left;
    bit finished, stalling;
    logic [VW+1:0] snap;
    c = 0; p = 0; g = 0;
    n_emit = 0; n_done = 0; n_unstable = 0; timed_out = 0;
    stall_left = stall; stalling = (stall > 0); finished = 1'b0;
    snap = '0;
    ofm_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = dbl_start && (cyc == 6 || cyc == 17);
      if (done0) n_done++;
      if (stalling && n_emit == 0 && stall_left < stall) begin
        if (!ofm_valid0 || {ofm0, ofm_pix0, ofm_grp0} !== snap) n_unstable++;
      end
      if (ofm_valid0) begin
        if (stalling && n_emit == 0 && stall_left > 0) begin
          if (stall_left == stall) snap = {ofm0, ofm_pix0, ofm_grp0};
          stall_left--;
          ofm_ready = 1'b0;
        end else begin
          ofm_ready = 1'b1;
          if (n_emit < 8) begin
            got0[n_emit]    = ofm0;
            got1[n_emit]    = ofm1;
            got_pix[n_emit] = int'(ofm_pix0);
            got_grp[n_emit] = int'(ofm_grp0);
          end
          n_emit++;
        end
      end else begin
        ofm_ready = 1'b1;
      end
      ifm_valid = (g < 2) && !(gap && (cyc % 3 == 1));
      if (g < 2) ifm = ifm_mem[p][c];
      if (abort_g1 && ofm_grp0 == 1'b1 && ifm_ready0 && c == 2) begin
        finished = 1'b1;
      end else if (ifm_valid && ifm_ready0) begin
        c++;
        if (c == 4) begin
          c = 0; p++;
          if (p == 2) begin p = 0; g++; end
        end
      end
      if (n_done > 0 && !busy0) finished = 1'b1;
    end
    if (!finished) timed_out = 1;
    ifm_valid = 1'b0;
    start = 1'b0;
    ofm_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ofm0, ofm1} !== '0) begin
      errors++; $display("FAIL reset_ofm: got %h/%h want 0", ofm0, ofm1);
    end
    checks++;
    if ({ofm_valid0, ifm_ready0, busy0, done0, wt_addr0, ofm_pix0, ofm_grp0,
         ofm_valid1, ifm_ready1, busy1, done1, wt_addr1, ofm_pix1, ofm_grp1} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b rdy=%b busy=%b done=%b addr=%0d pix=%0d grp=%0d want all 0",
               ofm_valid0, ifm_ready0, busy0, done0, wt_addr0, ofm_pix0, ofm_grp0);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    load_uniform(16'h0100, 16'h0100);
    run_layer(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 0) begin errors++; $display("FAIL basic_timeout: layer did not finish"); end
    checks++;
    if (n_emit !== 4 || n_done !== 1) begin
      errors++; $display("FAIL basic_counts: emits=%0d done=%0d want 4/1", n_emit, n_done);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0[k] !== 32'h0400_0400 || got1[k] !== 32'h0400_0400) begin
        errors++; $display("FAIL basic_ofm[%0d]: got %h/%h want 04000400", k, got0[k], got1[k]);
      end
      checks++;
      if (got_pix[k] !== k % 2 || got_grp[k] !== k / 2) begin
        errors++; $display("FAIL basic_coord[%0d]: got pix=%0d grp=%0d want %0d/%0d",
                           k, got_pix[k], got_grp[k], k % 2, k / 2);
      end
    end
  endtask

  task automatic test_relu;
    load_uniform(16'h0100, 16'hFF00);
    run_layer(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 0 || n_emit !== 4) begin
      errors++; $display("FAIL relu_counts: emits=%0d timeout=%0d want 4/0", n_emit, timed_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0[k] !== 32'h0000_0000 || got1[k] !== 32'hFC00_FC00) begin
        errors++; $display("FAIL relu_ofm[%0d]: got %h/%h want 00000000/fc00fc00", k, got0[k], got1[k]);
      end
    end
  endtask

  task automatic test_saturate;
    load_uniform(16'h7FFF, 16'h7FFF);
    run_layer(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 0 || n_emit !== 4) begin
      errors++; $display("FAIL sat_counts: emits=%0d timeout=%0d want 4/0", n_emit, timed_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0[k] !== 32'h7FFF_7FFF || got1[k] !== 32'h7FFF_7FFF) begin
        errors++; $display("FAIL sat_ofm[%0d]: got %h/%h want 7fff7fff", k, got0[k], got1[k]);
      end
    end
  endtask

  task automatic test_stall_gaps;
    logic [VW-1:0] exp0 [0:3];
    logic [VW-1:0] exp1 [0:3];
    ifm_mem[0][0] = 16'h0100; ifm_mem[0][1] = 16'h0200; ifm_mem[0][2] = 16'h0000; ifm_mem[0][3] = 16'hFF00;
    ifm_mem[1][0] = 16'h0080; ifm_mem[1][1] = 16'h0100; ifm_mem[1][2] = 16'h0100; ifm_mem[1][3] = 16'h0100;
    for (int c = 0; c < 4; c++) begin
      wt_mem[c]     = {16'h0200, 16'h0100};
      wt_mem[4 + c] = {16'h0080, 16'hFF00};
    end
    bias_mem[0] = {16'h0000, 16'h0100};
    bias_mem[1] = {16'hFF80, 16'h0000};
    exp0[0] = {16'h0400, 16'h0300}; exp1[0] = {16'h0400, 16'h0300};
    exp0[1] = {16'h0700, 16'h0480}; exp1[1] = {16'h0700, 16'h0480};
    exp0[2] = {16'h0080, 16'h0000}; exp1[2] = {16'h0080, 16'hFE00};
    exp0[3] = {16'h0140, 16'h0000}; exp1[3] = {16'h0140, 16'hFC80};
    run_layer(1'b1, 5, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 0 || n_emit !== 4 || n_done !== 1) begin
      errors++; $display("FAIL stall_counts: emits=%0d done=%0d timeout=%0d want 4/1/0", n_emit, n_done, timed_out);
    end
    checks++;
    if (n_unstable !== 0) begin
      errors++; $display("FAIL stall_hold: %0d unstable cycles want 0", n_unstable);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0[k] !== exp0[k] || got1[k] !== exp1[k]) begin
        errors++; $display("FAIL stall_ofm[%0d]: got %h/%h want %h/%h", k, got0[k], got1[k], exp0[k], exp1[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    load_uniform(16'h0100, 16'h0100);
    run_layer(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (timed_out !== 0 || n_emit !== 2) begin
      errors++; $display("FAIL midrst_reach: emits=%0d timeout=%0d want 2/0", n_emit, timed_out);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({ofm0, ofm1} !== '0) begin
      errors++; $display("FAIL midrst_ofm: got %h/%h want 0", ofm0, ofm1);
    end
    checks++;
    if ({ofm_valid0, ifm_ready0, busy0, done0, wt_addr0, ofm_pix0, ofm_grp0} !== '0) begin
      errors++;
      $display("FAIL midrst_ctrl: valid=%b rdy=%b busy=%b done=%b addr=%0d pix=%0d grp=%0d want all 0",
               ofm_valid0, ifm_ready0, busy0, done0, wt_addr0, ofm_pix0, ofm_grp0);
    end
    @(posedge clk); #1 rst = 1'b1;
    run_layer(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 0 || n_emit !== 4 || n_done !== 1) begin
      errors++; $display("FAIL midrst_rerun: emits=%0d done=%0d timeout=%0d want 4/1/0", n_emit, n_done, timed_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0[k] !== 32'h0400_0400 || got_pix[k] !== k % 2 || got_grp[k] !== k / 2) begin
        errors++; $display("FAIL midrst_ofm[%0d]: got %h pix=%0d grp=%0d want 04000400 %0d/%0d",
                           k, got0[k], got_pix[k], got_grp[k], k % 2, k / 2);
      end
    end
  endtask

  task automatic test_start_busy;
    load_uniform(16'h0100, 16'h0100);
    run_layer(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (timed_out !== 0 || n_emit !== 4 || n_done !== 1) begin
      errors++; $display("FAIL busy_counts: emits=%0d done=%0d timeout=%0d want 4/1/0", n_emit, n_done, timed_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_pix[k] !== k % 2 || got_grp[k] !== k / 2) begin
        errors++; $display("FAIL busy_coord[%0d]: got pix=%0d grp=%0d want %0d/%0d",
                           k, got_pix[k], got_grp[k], k % 2, k / 2);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || ofm_valid0 !== 1'b0) begin
      errors++; $display("FAIL busy_idle: busy=%b valid=%b want 0/0", busy0, ofm_valid0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 8; a++) wt_mem[a] = '0;
    bias_mem[0] = '0;
    bias_mem[1] = '0;
    test_reset();
    test_basic();
    test_relu();
    test_saturate();
    test_stall_gaps();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
